debug_dump_tx: RTL
==================

# debug_dump_tx

Debug-unit frame serializer: on a start pulse it reads a snapshot of pipeline latches and register file word by word and streams it as a byte frame into the UART TX FIFO, respecting FIFO backpressure. It is the transmit-side counterpart of the debugger's UART command receive path. It sits between the debugger's snapshot word mux and the UART TX FIFO write port.

## Interface
- NUM_WORDS, 36, 32-bit words per frame; legal range 1..255.
- WORD_SIZE, 32, snapshot word width; fixed at 32, four bytes per word.
- IDX_W, 8, width of the word index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request to send one frame; honoured only in IDLE.
- o_word_idx  out  IDX_W  index of the snapshot word requested, 0..NUM_WORDS-1.
- i_word_data  in  WORD_SIZE  snapshot word for o_word_idx; valid in the same cycle (combinational mux in the debugger).
- o_tx_data  out  8  byte for the TX FIFO.
- o_tx_wr  out  1  FIFO push strobe; byte is taken on the edge that ends a cycle where o_tx_wr=1.
- i_tx_full  in  1  TX FIFO full.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last frame byte has been pushed.

## Operation
- Frame: 0xA5, NUM_WORDS[7:0], then each word 0..NUM_WORDS-1 little-endian (bits [7:0] first), then optional checksum.
- States: IDLE, HDR, CNT, LOAD, BYTE, CSUM, DONE.
- IDLE: on i_start=1 go to HDR; clear word index, byte counter and checksum.
- HDR / CNT / BYTE / CSUM are push states: o_tx_wr = (push state) & ~i_tx_full, combinational. Advance only when a push occurs; otherwise hold state and o_tx_data.
- HDR pushes 0xA5 -> CNT. CNT pushes NUM_WORDS[7:0] -> LOAD.
- LOAD: capture i_word_data into a 32-bit shift register (one cycle, no push) -> BYTE with byte counter 0.
- BYTE: push shift[7:0]; on push, shift right 8, XOR the byte into the checksum, increment byte counter. After the 4th push: if o_word_idx == NUM_WORDS-1 go to CSUM, else increment o_word_idx and go to LOAD.
- CSUM: push checksum (XOR of all data bytes; header and count excluded) -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- i_start while o_busy=1 is ignored and not queued.
- Reset values: state IDLE, o_tx_wr 0, o_tx_data 0x00, o_word_idx 0, o_busy 0, o_done 0, checksum 0.
- Reset asserted mid-frame: immediate return to IDLE; partial frame is abandoned; no o_done.

## Timing
- Edge 0 is the edge that samples i_start. With i_tx_full never asserted: HDR push ends at edge 1, CNT at edge 2, each word takes 5 edges (LOAD + 4 BYTE), CSUM push ends at edge 3+5N, and o_done is high in the cycle after edge 3+5N (N = NUM_WORDS).
- Each cycle with i_tx_full=1 in a push state adds exactly one cycle; no byte is dropped or duplicated.
- o_word_idx stays stable during LOAD and all four BYTE cycles of its word.
- Minimum gap between consecutive frames: one IDLE cycle after o_done.

## Configuration
- DEBUG_DUMP_CHECKSUM_EN defined: CSUM state present; frame is 2+4N+1 bytes.
- Not defined: after the last BYTE push go directly to DONE; frame is 2+4N bytes; o_done is high in the cycle after edge 2+5N; no checksum logic.

## Test plan
- NUM_WORDS=2, words 0x11223344 and 0xAABBCCDD, FIFO never full -> bytes A5 02 44 33 22 11 DD CC BB AA 44; o_done high in the cycle after edge 13.
- Same frame with i_tx_full held high 5 cycles while the byte 0x22 is pending -> identical byte sequence; o_done 5 cycles later (after edge 18).
- i_start pulsed again at edge 4 of a frame -> ignored; exactly one frame; o_busy stays high until o_done.
- i_rst low at edge 6 mid-frame -> o_tx_wr 0, o_busy 0, o_word_idx 0 immediately; no o_done; the next i_start sends a complete frame starting with A5.
- Macro undefined, same data as the first test -> 10 bytes ending with AA; o_done high in the cycle after edge 12.
- NUM_WORDS=1, word 0x000000FF -> A5 01 FF 00 00 00 FF; o_word_idx stays 0 throughout.

Source files
------------

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: streams 0xA5, NUM_WORDS, then snapshot words little-endian (plus XOR checksum when DEBUG_DUMP_CHECKSUM_EN) into the UART TX FIFO.
// Latency: header push ends one edge after i_start; 5 cycles per word; o_done pulses the cycle after the final push.
// Backpressure: i_tx_full stalls any push state for that cycle; state and o_tx_data hold, no byte is lost or repeated.
module debug_dump_tx #(
    parameter int NUM_WORDS = 36,
    parameter int WORD_SIZE = 32,
    parameter int IDX_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [IDX_W-1:0]     o_word_idx,
    input  logic [WORD_SIZE-1:0] i_word_data,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_wr,
    input  logic                 i_tx_full,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {IDLE, HDR, CNT, LOAD, BYTE, CSUM, DONE} state_t;

    localparam logic [7:0]       CNT_BYTE = 8'(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t               state;
    logic [WORD_SIZE-1:0] shift;
    logic [1:0]           byte_cnt;
    logic                 push;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign push    = ((state == HDR) || (state == CNT) || (state == BYTE) || (state == CSUM)) && !i_tx_full;
    assign o_tx_wr = push;

    // o_tx_data always holds the byte being offered; shift holds the bytes still to come in the current word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            shift      <= '0;
            byte_cnt   <= 2'd0;
            o_word_idx <= '0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= HDR;
                        o_word_idx <= '0;
                        byte_cnt   <= 2'd0;
                        o_tx_data  <= 8'hA5;
                        o_busy     <= 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end
                HDR: begin
                    if (push) begin
                        state     <= CNT;
                        o_tx_data <= CNT_BYTE;
                    end
                end
                CNT: begin
                    if (push) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    o_tx_data <= i_word_data[7:0];
                    shift     <= i_word_data >> 8;
                    byte_cnt  <= 2'd0;
                    state     <= BYTE;
                end
                BYTE: begin
                    if (push) begin
                        o_tx_data <= shift[7:0];
                        shift     <= shift >> 8;
                        byte_cnt  <= byte_cnt + 2'd1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        csum      <= csum ^ o_tx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (o_word_idx == LAST_IDX) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                                state     <= CSUM;
                                o_tx_data <= csum ^ o_tx_data;
`else
                                state     <= DONE;
                                o_done    <= 1'b1;
`endif
                            end else begin
                                o_word_idx <= o_word_idx + IDX_W'(1);
                                state      <= LOAD;
                            end
                        end
                    end
                end
`ifdef DEBUG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (push) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
